i2s_rx: RTL and testbench

//  I2S audio receiver: the capture counterpart of the DAC serial output. Oversamples external

---
 rtl/i2s_pkg.sv | 29 ++
 rtl/i2s_rx_if.sv | 12 +
 rtl/i2s_edge_sync.sv | 30 +++
 rtl/i2s_rx.sv | 202 ++++++++++++++++++++
 tb/tb_i2s_rx.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared constants, FSM encoding and the sample magnitude helper for the I2S receiver.
package i2s_pkg;

  localparam int SAMPLE_W_DEF    = 16;
  localparam int ADDR_W_DEF      = 9;
  localparam int SYNC_STAGES_DEF = 3;

  localparam int                BITCNT_W   = 6;
  localparam logic [BITCNT_W-1:0] BITCNT_MAX = 6'd63;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_t;

  // |w| for a two's complement word; the single unrepresentable magnitude clamps to all-ones.
  function automatic logic [SAMPLE_W_DEF-2:0] abs_sat(input logic [SAMPLE_W_DEF-1:0] w);
    logic [SAMPLE_W_DEF-1:0] neg;
    neg = ~w + {{(SAMPLE_W_DEF-1){1'b0}}, 1'b1};
    if (!w[SAMPLE_W_DEF-1]) begin
      return w[SAMPLE_W_DEF-2:0];
    end else if (w == {1'b1, {(SAMPLE_W_DEF-1){1'b0}}}) begin
      return {(SAMPLE_W_DEF-1){1'b1}};
    end else begin
      return neg[SAMPLE_W_DEF-2:0];
    end
  endfunction

endpackage

// File: rtl/i2s_rx_if.sv
// Sample buffer write port: the receiver is master, the capture RAM is slave.
interface i2s_rx_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  modport master (output buf_we, buf_addr, buf_data);
  modport slave  (input  buf_we, buf_addr, buf_data);
endinterface

// File: rtl/i2s_edge_sync.sv
// Multi-flop synchronizer for one asynchronous pin plus rise/fall detect on the synced level.
module i2s_edge_sync #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clkin,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S capture: oversampled SCLK/LRCK/SDIN, 16-bit L/R deserializer, {R,L} frames to a wrapping buffer.
// Optional peak meters are built when I2S_RX_PEAK_EN is defined.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                i2s_sclk,
  input  logic                i2s_lrck,
  input  logic                i2s_sdin,
  input  logic                capture,
  input  logic                addr_load,
  input  logic [ADDR_W-1:0]   addr_load_val,
  i2s_rx_if.master            bus,
  output logic [SAMPLE_W-1:0] smp_left,
  output logic [SAMPLE_W-1:0] smp_right,
  output logic                rx_status,
  output logic                frame_err
`ifdef I2S_RX_PEAK_EN
  ,
  input  logic                peak_clr,
  output logic [SAMPLE_W-2:0] peak_l,
  output logic [SAMPLE_W-2:0] peak_r
`endif
);

  localparam logic [BITCNT_W-1:0] W_SLOT = BITCNT_W'(SAMPLE_W);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_lrck, w_lrck_rise, w_lrck_fall;
  logic w_sdin, w_sdin_rise, w_sdin_fall;
  logic w_unused_edges;

  i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clkin(clkin), .reset(reset), .i_async(i2s_sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrck (
    .clkin(clkin), .reset(reset), .i_async(i2s_lrck),
    .o_level(w_lrck), .o_rise(w_lrck_rise), .o_fall(w_lrck_fall));
  i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sdin (
    .clkin(clkin), .reset(reset), .i_async(i2s_sdin),
    .o_level(w_sdin), .o_rise(w_sdin_rise), .o_fall(w_sdin_fall));

  assign w_unused_edges = w_sclk_lvl ^ w_sclk_fall ^ w_lrck_rise ^ w_lrck_fall ^
                          w_sdin_rise ^ w_sdin_fall;

  i2s_state_t              r_state, w_state_nxt;
  logic                    r_lrck_prev;
  logic [BITCNT_W-1:0]     r_bitcnt, w_cnt_nxt;
  logic [SAMPLE_W-1:0]     r_shift, w_shift_nxt;
  logic [SAMPLE_W-1:0]     r_left_hold;
  logic                    r_left_valid;
  logic [2*SAMPLE_W-1:0]   r_frame;
  logic                    r_emit_pend, r_capture_prev, r_frame_err;
  logic                    r_buf_we;
  logic [ADDR_W-1:0]       r_buf_addr;
  logic [2*SAMPLE_W-1:0]   r_buf_data;
  logic [SAMPLE_W-1:0]     r_smp_left, r_smp_right;
  logic w_lrck_chg, w_short, w_finalize, w_left_done, w_emit, w_emit_go, w_capture_rise;

  assign w_lrck_chg     = w_lrck ^ r_lrck_prev;
  assign w_cnt_nxt      = (r_bitcnt == BITCNT_MAX) ? r_bitcnt : r_bitcnt + 6'd1;
  // The bit on a word-select change rise still belongs to the slot that is ending.
  assign w_shift_nxt    = (r_bitcnt < W_SLOT) ? {r_shift[SAMPLE_W-2:0], w_sdin} : r_shift;
  assign w_short        = (w_cnt_nxt < W_SLOT);
  assign w_capture_rise = capture & ~r_capture_prev;
  assign w_emit_go      = r_emit_pend & capture;

  // Next state and slot-end decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_finalize  = 1'b0;
    w_left_done = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (capture && w_sclk_rise && w_lrck_chg && !w_lrck) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_SYNC;
        end
      end
      ST_RUN: begin
        if (!capture) begin
          w_state_nxt = ST_SYNC;
        end else begin
          w_state_nxt = ST_RUN;
          if (w_sclk_rise && w_lrck_chg) begin
            w_finalize = 1'b1;
            if (w_lrck) begin
              w_left_done = !w_short;
            end else begin
              w_emit = r_left_valid && !w_short;
            end
          end else begin
            w_finalize = 1'b0;
          end
        end
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clkin) begin
    if (reset) r_state <= ST_SYNC;
    else       r_state <= w_state_nxt;
  end

  // Serial shifter and bit counter, restarted at every slot boundary.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_lrck_prev <= 1'b0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
    end else if (w_sclk_rise) begin
      r_lrck_prev <= w_lrck;
      if (w_lrck_chg) begin
        r_bitcnt <= '0;
        r_shift  <= '0;
      end else begin
        r_bitcnt <= w_cnt_nxt;
        r_shift  <= w_shift_nxt;
      end
    end
  end

  // Left/right pairing, error flag and frame staging.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_capture_prev <= 1'b0;
      r_left_valid   <= 1'b0;
      r_left_hold    <= '0;
      r_frame_err    <= 1'b0;
      r_emit_pend    <= 1'b0;
      r_frame        <= '0;
    end else begin
      r_capture_prev <= capture;
      if (w_state_nxt == ST_SYNC) r_left_valid <= 1'b0;
      else if (w_finalize)        r_left_valid <= w_left_done;
      if (w_left_done) r_left_hold <= w_shift_nxt;
      if (w_capture_rise)             r_frame_err <= 1'b0;
      else if (w_finalize && w_short) r_frame_err <= 1'b1;
      r_emit_pend <= w_emit;
      if (w_emit) r_frame <= {w_shift_nxt, r_left_hold};
    end
  end

  // Buffer write port; a load coinciding with an emit redirects that write.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_buf_we    <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
      r_smp_left  <= '0;
      r_smp_right <= '0;
    end else begin
      r_buf_we <= w_emit_go;
      if (w_emit_go) begin
        r_buf_data  <= r_frame;
        r_smp_left  <= r_frame[SAMPLE_W-1:0];
        r_smp_right <= r_frame[2*SAMPLE_W-1:SAMPLE_W];
      end
      if (addr_load)     r_buf_addr <= addr_load_val;
      else if (r_buf_we) r_buf_addr <= r_buf_addr + ADDR_W'(1);
    end
  end

  assign bus.buf_we   = r_buf_we;
  assign bus.buf_addr = r_buf_addr;
  assign bus.buf_data = r_buf_data;
  assign smp_left     = r_smp_left;
  assign smp_right    = r_smp_right;
  assign rx_status    = r_buf_addr[ADDR_W-1];
  assign frame_err    = r_frame_err;

`ifdef I2S_RX_PEAK_EN
  logic [SAMPLE_W-2:0] r_peak_l, r_peak_r, w_abs_l, w_abs_r;

  assign w_abs_l = abs_sat(r_frame[SAMPLE_W-1:0]);
  assign w_abs_r = abs_sat(r_frame[2*SAMPLE_W-1:SAMPLE_W]);

  // Peak-hold meters; clear has priority over an update in the same cycle.
  always_ff @(posedge clkin) begin
    if (reset || peak_clr) begin
      r_peak_l <= '0;
      r_peak_r <= '0;
    end else if (w_emit_go) begin
      if (w_abs_l > r_peak_l) r_peak_l <= w_abs_l;
      if (w_abs_r > r_peak_r) r_peak_r <= w_abs_r;
    end
  end

  assign peak_l = r_peak_l;
  assign peak_r = r_peak_r;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: bit-level I2S driver, write monitor, hand-computed expectations.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        reset, sclk, lrck, sdin, capture, addr_load;
  logic [8:0]  addr_load_val;
  logic [15:0] smp_left, smp_right;
  logic        rx_status, frame_err;
`ifdef I2S_RX_PEAK_EN
  logic        peak_clr;
  logic [14:0] peak_l, peak_r;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [8:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic        wr_stat[$];

  always #5 clk = ~clk;

  i2s_rx_if #(.ADDR_W(9), .DATA_W(32)) bus_if ();

  i2s_rx dut (
    .clkin(clk), .reset(reset), .i2s_sclk(sclk), .i2s_lrck(lrck), .i2s_sdin(sdin),
    .capture(capture), .addr_load(addr_load), .addr_load_val(addr_load_val),
    .bus(bus_if), .smp_left(smp_left), .smp_right(smp_right),
    .rx_status(rx_status), .frame_err(frame_err)
`ifdef I2S_RX_PEAK_EN
    , .peak_clr(peak_clr), .peak_l(peak_l), .peak_r(peak_r)
`endif
  );

  always @(negedge clk) begin
    if (bus_if.buf_we) begin
      wr_addr.push_back(bus_if.buf_addr);
      wr_data.push_back(bus_if.buf_data);
      wr_stat.push_back(rx_status);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input int idx, input logic [8:0] a, input logic [31:0] d, input logic st);
    logic [8:0]  ga;
    logic [31:0] gd;
    logic        gs;
    ga = (idx < wr_addr.size()) ? wr_addr[idx] : 9'bx;
    gd = (idx < wr_data.size()) ? wr_data[idx] : 32'bx;
    gs = (idx < wr_stat.size()) ? wr_stat[idx] : 1'bx;
    chk($sformatf("wr%0d_addr", idx), {23'd0, ga}, {23'd0, a});
    chk($sformatf("wr%0d_data", idx), gd, d);
    chk($sformatf("wr%0d_stat", idx), {31'd0, gs}, {31'd0, st});
  endtask

  // One serial bit: 4 clk setup with SCLK low, 4 clk high, 4 clk low. ld pulses addr_load
  // exactly on the cycle the resulting frame strobe is registered (latency 3 sync + 2).
  task automatic drive_bit(input logic lr, input logic sd, input logic ld);
    lrck = lr;
    sdin = sd;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ld && i == 3) addr_load = 1'b1;
    end
    sclk = 1'b0;
    @(negedge clk);
    addr_load = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // A slot of n rises: word select flips on the last one (one-bit I2S delay).
  task automatic send_slot(input logic ch, input logic [15:0] w, input int n, input logic ld_last);
    for (int i = 0; i < n; i++) begin
      drive_bit((i == n - 1) ? ~ch : ch, (i < 16) ? w[15 - i] : 1'b0, ld_last && (i == n - 1));
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl, input logic ld);
    send_slot(1'b0, l, nl, 1'b0);
    send_slot(1'b1, r, 16, ld);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rw;
    reset = 1'b1; sclk = 1'b0; lrck = 1'b1; sdin = 1'b0; capture = 1'b0;
    addr_load = 1'b0; addr_load_val = 9'h000;
`ifdef I2S_RX_PEAK_EN
    peak_clr = 1'b0;
`endif
    repeat (4) @(negedge clk);
    chk("rst_we", {31'd0, bus_if.buf_we}, 32'd0);
    chk("rst_addr", {23'd0, bus_if.buf_addr}, 32'd0);
    chk("rst_data", bus_if.buf_data, 32'd0);
    chk("rst_smp", {smp_right, smp_left}, 32'd0);
    chk("rst_flags", {30'd0, rx_status, frame_err}, 32'd0);
    reset = 1'b0;
    capture = 1'b1;
    repeat (2) @(negedge clk);

    // 1: sync on a dummy right slot, then two good frames at 0 and 1
    send_slot(1'b1, 16'h0000, 16, 1'b0);
    chk("sync_no_write", wr_data.size(), 32'd0);
    send_frame(16'h1234, 16'hABCD, 16, 1'b0);
    send_frame(16'h7FFF, 16'h8001, 16, 1'b0);
    chk("t1_count", wr_data.size(), 32'd2);
    chk_wr(0, 9'h000, 32'hABCD1234, 1'b0);
    chk_wr(1, 9'h001, 32'h80017FFF, 1'b0);
    chk("t1_smp", {smp_right, smp_left}, 32'h80017FFF);
    chk("t1_addr", {23'd0, bus_if.buf_addr}, 32'h002);

    // 2: load 0x1FF while idle, two frames wrap the address
    addr_load_val = 9'h1FF;
    addr_load = 1'b1;
    @(negedge clk);
    addr_load = 1'b0;
    send_frame(16'h1111, 16'h2222, 16, 1'b0);
    send_frame(16'h3333, 16'h4444, 16, 1'b0);
    chk_wr(2, 9'h1FF, 32'h22221111, 1'b1);
    chk_wr(3, 9'h000, 32'h44443333, 1'b0);
    chk("t2_addr", {23'd0, bus_if.buf_addr}, 32'h001);

    // 3: 10-bit left slot -> sticky error, frame dropped; next good frame lands
    send_frame(16'hFFFF, 16'h5555, 10, 1'b0);
    chk("t3_err", {31'd0, frame_err}, 32'd1);
    chk("t3_count", wr_data.size(), 32'd4);
    send_frame(16'hCAFE, 16'hBEEF, 16, 1'b0);
    chk_wr(4, 9'h001, 32'hBEEFCAFE, 1'b0);
    chk("t3_err_sticky", {31'd0, frame_err}, 32'd1);
    chk("t3_smp", {smp_right, smp_left}, 32'hBEEFCAFE);

    // 4: capture dropped mid right slot, raised again before its end
    send_slot(1'b0, 16'h1357, 16, 1'b0);
    rw = 16'hFACE;
    for (int i = 0; i < 16; i++) begin
      if (i == 8)  capture = 1'b0;
      if (i == 12) capture = 1'b1;
      drive_bit((i == 15) ? 1'b0 : 1'b1, rw[15 - i], 1'b0);
    end
    chk("t4_no_write", wr_data.size(), 32'd5);
    chk("t4_err_clr", {31'd0, frame_err}, 32'd0);
    send_frame(16'h2468, 16'h9ABC, 16, 1'b0);
    chk_wr(5, 9'h002, 32'h9ABC2468, 1'b0);

    // 5: addr_load on the emit cycle redirects that write
    addr_load_val = 9'h040;
    send_frame(16'h0F0F, 16'hF0F0, 16, 1'b1);
    chk_wr(6, 9'h040, 32'hF0F00F0F, 1'b0);
    chk("t5_addr", {23'd0, bus_if.buf_addr}, 32'h041);
    chk("t5_count", wr_data.size(), 32'd7);

`ifdef I2S_RX_PEAK_EN
    // 6: peak meters with the most negative sample
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    chk("t6_clr0", {2'd0, peak_r, peak_l}, 32'd0);
    send_frame(16'h8000, 16'h0005, 16, 1'b0);
    send_frame(16'h0100, 16'hFFFE, 16, 1'b0);
    chk("t6_peak_l", {17'd0, peak_l}, 32'h7FFF);
    chk("t6_peak_r", {17'd0, peak_r}, 32'h0005);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    chk("t6_clr1", {2'd0, peak_r, peak_l}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
